zapper_hit_detector: RTL and testbench

- Producer of the `shot` input consumed by the duck sprite mover; it is the light-gun end of the duck/shot interface.
- Converts a player trigger into a one-frame screen-flash scan. It samples `is_duck` at the crosshair and reports hit or miss, aligned to the frame-edge cycle the duck mover samples.
- Tracks remaining ammunition per duck.
- Sits between the input front-end (button or mouse trigger, crosshair position) and the duck/colour-mapper logic.

---
 rtl/duckhunt_pkg.sv | 16 +
 rtl/trigger_conditioner.sv | 62 ++++++
 rtl/zapper_hit_detector.sv | 129 ++++++++++++
 tb/tb_zapper_hit_detector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/duckhunt_pkg.sv
// Shared game constants, zapper FSM states and pixel-distance helper.
package duckhunt_pkg;

   localparam logic [1:0] PLAY           = 2'b10;
   localparam int         HIT_RADIUS_DEF = 8;

   typedef enum logic [1:0] {IDLE, ARM, SCAN, REPORT} zapper_state_t;

   // Distance is taken on 11 bits so screen coordinates never wrap around.
   function automatic logic [10:0] abs_dist(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[10] ? $unsigned(-d) : $unsigned(d);
   endfunction

endpackage

// File: rtl/trigger_conditioner.sv
// Two-flop synchronizer plus rising-edge pulse; optional level debounce
// when built with SHOT_DEBOUNCE_EN and enabled on the instance.
module trigger_conditioner #(
   parameter bit DEBOUNCE_EN     = 1'b0,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic Clk,
   input  logic clear,
   input  logic raw,
   output logic pulse
);

`ifdef SHOT_DEBOUNCE_EN
   localparam bit DB_BUILD = 1'b1;
`else
   localparam bit DB_BUILD = 1'b0;
`endif

   logic [1:0] sync;
   logic       level;
   logic       level_d;

   always_ff @(posedge Clk) begin
      if (clear) sync <= '0;
      else       sync <= {sync[0], raw};
   end

   generate
      if (DB_BUILD && DEBOUNCE_EN && DEBOUNCE_CYCLES > 0) begin : g_db
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         logic [CW-1:0] cnt;
         logic          db;

         // The level only flips after the new value has been stable for the full count.
         always_ff @(posedge Clk) begin
            if (clear) begin
               cnt <= '0;
               db  <= 1'b0;
            end else if (sync[1] == db) begin
               cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               db  <= sync[1];
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         assign level = db;
      end else begin : g_raw
         assign level = sync[1];
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (clear) level_d <= 1'b0;
      else       level_d <= level;
   end

   assign pulse = level & ~level_d;

endmodule

// File: rtl/zapper_hit_detector.sv
// Light-gun hit detector: trigger -> one-frame flash scan -> hit/miss report on
// the duck mover's frame edge. SHOT_DEBOUNCE_EN enables trigger debounce.
module zapper_hit_detector
   import duckhunt_pkg::*;
#(
   parameter int MAX_SHOTS       = 3,
   parameter int HIT_RADIUS      = HIT_RADIUS_DEF,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [1:0] state,
   input  logic       trigger,
   input  logic       new_duck,
   input  logic [9:0] cross_x,
   input  logic [9:0] cross_y,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       is_duck,
   output logic       shot,
   output logic       miss,
   output logic       flash,
   output logic [1:0] shots_left,
   output logic       out_of_ammo
);

   localparam logic [1:0] AMMO_FULL = 2'(MAX_SHOTS);

   zapper_state_t zst;
   logic          clear;
   logic          frame_clk_delayed;
   logic          fe;
   logic          trig_pulse;
   logic          reload_pulse;
   logic          hit_flag;
   logic          in_window;
   logic [1:0]    ammo_now;
   logic          fire_ok;

   // Leaving PLAY behaves exactly like reset.
   assign clear = Reset | (state != PLAY);

   // Same registered edge as the duck mover so both blocks agree on the cycle.
   always_ff @(posedge Clk) begin
      if (clear) begin
         frame_clk_delayed <= 1'b0;
         fe                <= 1'b0;
      end else begin
         frame_clk_delayed <= frame_clk;
         fe                <= frame_clk & ~frame_clk_delayed;
      end
   end

   trigger_conditioner #(
      .DEBOUNCE_EN     (1'b1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_trig (
      .Clk   (Clk),
      .clear (clear),
      .raw   (trigger),
      .pulse (trig_pulse)
   );

   trigger_conditioner #(
      .DEBOUNCE_EN     (1'b0),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_reload (
      .Clk   (Clk),
      .clear (clear),
      .raw   (new_duck),
      .pulse (reload_pulse)
   );

   assign in_window = (abs_dist(DrawX, cross_x) <= 11'(HIT_RADIUS)) &&
                      (abs_dist(DrawY, cross_y) <= 11'(HIT_RADIUS));

   // A reload in the same cycle is applied before the shot is charged.
   assign ammo_now = reload_pulse ? AMMO_FULL : shots_left;
   assign fire_ok  = (zst == IDLE) && trig_pulse && (ammo_now != 2'd0);

   always_ff @(posedge Clk) begin
      if (clear) begin
         zst        <= IDLE;
         hit_flag   <= 1'b0;
         shots_left <= AMMO_FULL;
         shot       <= 1'b0;
         miss       <= 1'b0;
         flash      <= 1'b0;
      end else begin
         if (fire_ok)           shots_left <= ammo_now - 2'd1;
         else if (reload_pulse) shots_left <= AMMO_FULL;

         case (zst)
            IDLE: begin
               if (fire_ok) zst <= ARM;
            end
            ARM: begin
               if (fe) begin
                  zst      <= SCAN;
                  hit_flag <= 1'b0;
                  flash    <= 1'b1;
               end
            end
            SCAN: begin
               if (fe) begin
                  zst   <= REPORT;
                  flash <= 1'b0;
                  shot  <= hit_flag;
                  miss  <= ~hit_flag;
               end else if (is_duck && in_window) begin
                  hit_flag <= 1'b1;
               end
            end
            REPORT: begin
               if (fe) begin
                  zst  <= IDLE;
                  shot <= 1'b0;
                  miss <= 1'b0;
               end
            end
            default: zst <= IDLE;
         endcase
      end
   end

   assign out_of_ammo = (shots_left == 2'd0) && (zst == IDLE);

endmodule

// File: tb/tb_zapper_hit_detector.sv
// Directed shot sequence with randomized pixel traffic, checked against a
// frame-level model of flash / report windows, hit decision and ammo count.
module tb_zapper_hit_detector;

   localparam int MAX_SHOTS = 3;
   localparam int FRAME     = 64;
   localparam int HIST      = 20000;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [1:0] state;
   logic       trigger;
   logic       new_duck;
   logic [9:0] cross_x, cross_y, DrawX, DrawY;
   logic       is_duck;
   logic       shot, miss, flash, out_of_ammo;
   logic [1:0] shots_left;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   bit hit_hist [HIST];

   // scene: mode 0 = duck rectangle, mode 1 = single duck pixel at (px,py)
   int mode, cx, cy, px, py;
   int model_shots;

   always #10 Clk = ~Clk;

   zapper_hit_detector dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .state       (state),
      .trigger     (trigger),
      .new_duck    (new_duck),
      .cross_x     (cross_x),
      .cross_y     (cross_y),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .is_duck     (is_duck),
      .shot        (shot),
      .miss        (miss),
      .flash       (flash),
      .shots_left  (shots_left),
      .out_of_ammo (out_of_ammo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
   endfunction

   // Advance one clock, then drive this cycle's frame level and pixel.
   task automatic tick();
      int  x, y;
      bit  duck;
      @(posedge Clk);
      #1;
      cyc++;
      frame_clk = ((cyc % FRAME) >= FRAME / 2);
      if (mode == 0) begin
         if ($urandom_range(0, 3) == 0) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
         end else begin
            x = clamp(cx + int'($urandom_range(0, 24)) - 12);
            y = clamp(cy + int'($urandom_range(0, 24)) - 12);
         end
         duck = (x >= 320 && x <= 383 && y >= 245 && y <= 308);
      end else begin
         if (cyc % 8 == 0) begin
            x = px;
            y = py;
         end else begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
         end
         duck = (x == px && y == py);
      end
      DrawX   = 10'(x);
      DrawY   = 10'(y);
      is_duck = duck;
      cross_x = 10'(cx);
      cross_y = 10'(cy);
      if (cyc < HIST) hit_hist[cyc] = duck && iabs(x - cx) <= 8 && iabs(y - cy) <= 8;
   endtask

   // One trigger attempt. Frame edges are seen by the DUT at cycles = 33 mod 64,
   // so with the trigger at 40 mod 64: arm at a, flash (a,b], report (b,c].
   task automatic fire(input string tag, input bit with_reload, input bit retrig,
                       input bit abort);
      int t0, a, b, c;
      bit acc, hit, aborted;
      while (cyc % FRAME != 40) tick();
      t0 = cyc;
      trigger = 1'b1;
      if (with_reload) new_duck = 1'b1;
      acc = ((with_reload ? MAX_SHOTS : model_shots) > 0);
      if (with_reload) model_shots = MAX_SHOTS;
      if (acc) model_shots--;
      a = t0 + 5;
      while (a % FRAME != FRAME / 2 + 1) a++;
      b   = a + FRAME;
      c   = b + FRAME;
      hit = 1'b0;
      while (cyc < c + 3) begin
         tick();
         aborted = abort && (cyc > a + 10);
         if (cyc == t0 + 4) begin
            trigger  = 1'b0;
            new_duck = 1'b0;
         end
         if (retrig && cyc == a + 20) trigger = 1'b1;
         if (retrig && cyc == a + 24) trigger = 1'b0;
         if (cyc == b) begin
            hit = 1'b0;
            for (int k = a + 1; k < b; k++) hit |= hit_hist[k];
         end
         chk({tag, "/flash"}, flash, !aborted && acc && cyc > a && cyc <= b);
         chk({tag, "/shot"},  shot,  !aborted && acc && cyc > b && cyc <= c && hit);
         chk({tag, "/miss"},  miss,  !aborted && acc && cyc > b && cyc <= c && !hit);
         if (cyc == a || cyc == c + 3) begin
            chk({tag, "/shots_left"}, shots_left, model_shots);
            chk({tag, "/out_of_ammo"}, out_of_ammo, (cyc == a && acc) ? 0 : (model_shots == 0));
         end
         if (abort && cyc == a + 10) state = 2'b00;
         if (abort && cyc == a + 11) begin
            model_shots = MAX_SHOTS;
            chk({tag, "/shots_left"}, shots_left, model_shots);
            chk({tag, "/out_of_ammo"}, out_of_ammo, 0);
            break;
         end
      end
      if (abort) begin
         while (cyc % FRAME != 10) tick();
         state = 2'b10;
         tick();
      end
   endtask

   initial begin
      mode = 0; cx = 330; cy = 250; px = 0; py = 0;
      Reset = 1'b1; state = 2'b10; trigger = 1'b0; new_duck = 1'b0;
      frame_clk = 1'b0; DrawX = '0; DrawY = '0; is_duck = 1'b0;
      cross_x = 10'(cx); cross_y = 10'(cy);
      model_shots = MAX_SHOTS;

      repeat (3) tick();
      chk("reset/shots_left", shots_left, MAX_SHOTS);
      chk("reset/flash", flash, 0);
      chk("reset/shot", shot, 0);
      chk("reset/miss", miss, 0);
      Reset = 1'b0;
      tick();
      chk("idle/shots_left", shots_left, MAX_SHOTS);
      chk("idle/out_of_ammo", out_of_ammo, 0);
      chk("idle/shot", shot, 0);
      chk("idle/miss", miss, 0);

      fire("hit", 0, 0, 0);
      cx = 100; cy = 400;
      fire("miss_retrig", 0, 1, 0);
      mode = 1; cx = 500; cy = 500; px = 508; py = 492;
      fire("radius8", 0, 0, 0);
      fire("no_ammo", 0, 0, 0);

      new_duck = 1'b1;
      repeat (4) tick();
      new_duck = 1'b0;
      repeat (4) tick();
      model_shots = MAX_SHOTS;
      chk("reload/shots_left", shots_left, model_shots);
      chk("reload/out_of_ammo", out_of_ammo, 0);

      px = 509; py = 500;
      fire("radius9", 0, 0, 0);
      cx = 0; cy = 300; px = 1023; py = 300;
      fire("no_wrap", 0, 0, 0);
      mode = 0; cx = 330; cy = 250;
      fire("simul_reload", 1, 0, 0);
      fire("abort", 0, 0, 1);

      for (int i = 0; i < 4; i++) begin
         cx = int'($urandom_range(300, 400));
         cy = int'($urandom_range(230, 330));
         fire("random", 0, (i == 1), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
